// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by masters and slaves,
// plus the SRAM slave FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Byte-enable synchronous SRAM with a registered read port
// that forwards a same-cycle write to the same word.
module ahb_sram_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDXW-1:0]       waddr_i,
  input  logic [BYTES-1:0]      wbe_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [IDXW-1:0]       raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
      if (we_i && (waddr_i == raddr_i)) begin
        for (int b = 0; b < BYTES; b++) begin
          if (wbe_i[b]) rdata_d[8*b +: 8] = wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address/data pipeline, optional wait
// states and the two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk_i,
  input  logic                  hresetn_i,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hreadyout_o,
  output logic                  hresp_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  sram_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dp_vld_q, dp_vld_d;
  logic        dp_wr_q, dp_wr_d;
  logic        dp_err_q, dp_err_d;
  logic [BYTES-1:0] dp_be_q, dp_be_d;
  logic [IDXW-1:0]  dp_idx_q, dp_idx_d;

  logic                  accept, acc_err, rdy, resp;
  logic [ADDR_WIDTH-1:0] word_idx, off, amask;
  logic [BYTES-1:0]      be;
  logic                  mem_we, mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused;

  assign unused   = ^{hburst_i, hprot_i};
  assign accept   = hsel_i && hready_i &&
                    (htrans_i inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign word_idx = haddr_i >> OFFW;

  always_comb begin
    be    = '0;
    off   = haddr_i & ADDR_WIDTH'(BYTES - 1);
    amask = (ADDR_WIDTH'(1) << hsize_i) - ADDR_WIDTH'(1);
    // A lane is enabled when it shares the access-sized chunk
    // with the start address.
    for (int b = 0; b < BYTES; b++) begin
      be[b] = (ADDR_WIDTH'(b) >> hsize_i) == (off >> hsize_i);
    end
    acc_err = (word_idx >= ADDR_WIDTH'(MEM_DEPTH)) ||
              (hsize_i > 3'(OFFW)) ||
              ((haddr_i & amask) != '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dp_vld_d = dp_vld_q;
    dp_wr_d  = dp_wr_q;
    dp_err_d = dp_err_q;
    dp_be_d  = dp_be_q;
    dp_idx_d = dp_idx_q;
    rdy      = 1'b1;
    resp     = HRESP_OKAY;
    unique case (state_q)
      ST_IDLE: begin end
      ST_WAIT: begin
        rdy   = 1'b0;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
      ST_ERR1: begin
        rdy     = 1'b0;
        resp    = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        resp    = HRESP_ERROR;
        state_d = ST_IDLE;
      end
    endcase
    // Data phase ends here; the next address phase overlaps it.
    if (rdy && hready_i) begin
      dp_vld_d = accept;
      dp_wr_d  = hwrite_i;
      dp_err_d = acc_err;
      dp_be_d  = be;
      dp_idx_d = word_idx[IDXW-1:0];
      if (accept && acc_err) begin
        state_d = ST_ERR1;
      end else if (accept && (WAIT_STATES > 0)) begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
    end
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_err_q <= 1'b0;
      dp_be_q  <= '0;
      dp_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dp_vld_q <= dp_vld_d;
      dp_wr_q  <= dp_wr_d;
      dp_err_q <= dp_err_d;
      dp_be_q  <= dp_be_d;
      dp_idx_q <= dp_idx_d;
    end
  end

  assign mem_we = rdy && hready_i && dp_vld_q &&
                  dp_wr_q && !dp_err_q;
  assign mem_re = accept && !hwrite_i && !acc_err;

  ahb_sram_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk_i   (hclk_i),
    .rst_ni  (hresetn_i),
    .we_i    (mem_we),
    .waddr_i (dp_idx_q),
    .wbe_i   (dp_be_q),
    .wdata_i (hwdata_i),
    .re_i    (mem_re),
    .raddr_i (word_idx[IDXW-1:0]),
    .rdata_o (mem_rdata)
  );

  assign hrdata_o    = (dp_vld_q && !dp_wr_q && !dp_err_q) ?
                       mem_rdata : '0;
  assign hreadyout_o = rdy;
  assign hresp_o     = resp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench: two slaves (0 and 2 wait states) on one bus, checked
// against a byte-array memory model.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dsel = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = '0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hsel0, hsel1;
  logic [31:0] rdata0, rdata1, rdata_m;
  logic        rdy0, rdy1, resp0, resp1, resp_m;

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [2][64];

  always #5 clk = ~clk;

  assign hsel0   = hsel & ~dsel;
  assign hsel1   = hsel & dsel;
  assign hready  = dsel ? rdy1 : rdy0;
  assign rdata_m = dsel ? rdata1 : rdata0;
  assign resp_m  = dsel ? resp1 : resp0;

  ahb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .MEM_DEPTH(DEPTH), .WAIT_STATES(0)
  ) u_dut0 (
    .hclk_i(clk), .hresetn_i(rstn), .hsel_i(hsel0),
    .haddr_i(haddr), .htrans_i(htrans), .hwrite_i(hwrite),
    .hsize_i(hsize), .hburst_i(hburst), .hprot_i(hprot),
    .hwdata_i(hwdata), .hready_i(hready),
    .hrdata_o(rdata0), .hreadyout_o(rdy0), .hresp_o(resp0)
  );

  ahb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .MEM_DEPTH(DEPTH), .WAIT_STATES(2)
  ) u_dut1 (
    .hclk_i(clk), .hresetn_i(rstn), .hsel_i(hsel1),
    .haddr_i(haddr), .htrans_i(htrans), .hwrite_i(hwrite),
    .hsize_i(hsize), .hburst_i(hburst), .hprot_i(hprot),
    .hwdata_i(hwdata), .hready_i(hready),
    .hrdata_o(rdata1), .hreadyout_o(rdy1), .hresp_o(resp1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input int d,
                                           input int a);
    int w;
    w = a & ~3;
    return {mdl[d][w+3], mdl[d][w+2], mdl[d][w+1], mdl[d][w]};
  endfunction

  // One isolated transfer; returns at the negedge of the final
  // data-phase cycle, with hwdata held through the next edge.
  task automatic do_txn(input string tag, input logic wr,
                        input logic [1:0] tr,
                        input logic [31:0] a,
                        input logic [2:0] sz,
                        input logic [31:0] wd,
                        output logic [31:0] rd);
    logic f_rsp, rsp, err;
    logic [31:0] exp_rd;
    int nw, d, ws;
    d   = int'(dsel);
    ws  = dsel ? 2 : 0;
    err = ((a >> 2) >= DEPTH) || (sz > 3'd2) ||
          ((a % (32'd1 << sz)) != 0);
    exp_rd = err ? 32'h0 : mdl_word(d, int'(a));
    hsel = 1'b1; htrans = tr; haddr = a;
    hwrite = wr; hsize = sz;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
    f_rsp = resp_m;
    nw = 0;
    while (hready !== 1'b1 && nw < 40) begin
      @(negedge clk);
      nw++;
    end
    rd  = rdata_m;
    rsp = resp_m;
    chk({tag, " resp"}, rsp, err);
    chk({tag, " first_resp"}, f_rsp, err);
    chk({tag, " stall"}, nw, err ? 1 : ws);
    if (!wr) chk({tag, " rdata"}, rd, exp_rd);
    if (wr && !err) begin
      for (int i = 0; i < (1 << sz); i++) begin
        mdl[d][int'(a) + i] = wd[8*((int'(a) + i) % 4) +: 8];
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, a, wd;
    logic [2:0]  sz;
    logic [1:0]  tr;
    logic [1:0]  idle_codes [2];
    idle_codes[0] = HTRANS_IDLE;
    idle_codes[1] = HTRANS_BUSY;

    repeat (3) @(negedge clk);
    chk("rst rdy0", rdy0, 1'b1);
    chk("rst resp0", resp0, HRESP_OKAY);
    chk("rst rdata0", rdata0, 32'h0);
    chk("rst rdy1", rdy1, 1'b1);
    chk("rst resp1", resp1, HRESP_OKAY);
    chk("rst rdata1", rdata1, 32'h0);
    rstn = 1'b1;

    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      for (int w = 0; w < 16; w++) begin
        do_txn("init", 1'b1, HTRANS_NONSEQ, 32'(w * 4),
               HSIZE_WORD, $urandom, rd);
      end
    end

    dsel = 1'b0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h10;
    hwrite = 1'b1; hsize = HSIZE_WORD;
    @(negedge clk);
    chk("b2b rdy_a", hready, 1'b1);
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    @(negedge clk);
    chk("b2b rdy_b", hready, 1'b1);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    chk("b2b rdata", rdata_m, 32'hDEADBEEF);
    chk("b2b resp", resp_m, HRESP_OKAY);
    mdl[0][16] = 8'hEF; mdl[0][17] = 8'hBE;
    mdl[0][18] = 8'hAD; mdl[0][19] = 8'hDE;

    do_txn("w11223344", 1'b1, HTRANS_NONSEQ, 32'h10,
           HSIZE_WORD, 32'h11223344, rd);
    do_txn("wbyte13", 1'b1, HTRANS_NONSEQ, 32'h13,
           HSIZE_BYTE, 32'hAAAAAAAA, rd);
    do_txn("rmerge", 1'b0, HTRANS_NONSEQ, 32'h10,
           HSIZE_WORD, 32'h0, rd);
    chk("merge value", rd, 32'hAA223344);

    dsel = 1'b1;
    do_txn("ws2 read", 1'b0, HTRANS_NONSEQ, 32'h8,
           HSIZE_WORD, 32'h0, rd);
    do_txn("ws2 half", 1'b1, HTRANS_SEQ, 32'h6,
           HSIZE_HALF, 32'h5A5A0000, rd);

    dsel = 1'b0;
    do_txn("err 1002", 1'b0, HTRANS_NONSEQ, 32'h1002,
           HSIZE_WORD, 32'h0, rd);
    do_txn("err mis", 1'b1, HTRANS_NONSEQ, 32'h12,
           HSIZE_WORD, 32'hFFFFFFFF, rd);
    do_txn("after mis", 1'b0, HTRANS_NONSEQ, 32'h10,
           HSIZE_WORD, 32'h0, rd);
    do_txn("err depth", 1'b1, HTRANS_NONSEQ, 32'h1000,
           HSIZE_BYTE, 32'h77777777, rd);
    do_txn("after depth", 1'b0, HTRANS_NONSEQ, 32'h0,
           HSIZE_WORD, 32'h0, rd);
    dsel = 1'b1;
    do_txn("err ws2", 1'b0, HTRANS_NONSEQ, 32'h1000,
           HSIZE_WORD, 32'h0, rd);

    for (int k = 0; k < 2; k++) begin
      dsel = 1'b0;
      hsel = 1'b1; htrans = idle_codes[k]; haddr = 32'h10;
      hwrite = 1'b1; hsize = HSIZE_WORD;
      @(negedge clk);
      hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hBADBAD00;
      chk("idle rdy", hready, 1'b1);
      chk("idle resp", resp_m, HRESP_OKAY);
      @(negedge clk);
      do_txn("idle noacc", 1'b0, HTRANS_NONSEQ, 32'h10,
             HSIZE_WORD, 32'h0, rd);
    end

    dsel = 1'b1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20;
    hwrite = 1'b1; hsize = HSIZE_WORD;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hC0FFEE11;
    chk("wait rdy", hready, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("mid rst rdy", hready, 1'b1);
    chk("mid rst resp", resp_m, HRESP_OKAY);
    chk("mid rst rdata", rdata_m, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    do_txn("no commit", 1'b0, HTRANS_NONSEQ, 32'h20,
           HSIZE_WORD, 32'h0, rd);

    for (int n = 0; n < 150; n++) begin
      dsel = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 3));
      a    = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1 && sz < 3'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0)
        a = 32'h1000 + 32'($urandom_range(0, 15));
      tr = $urandom_range(0, 1) == 1 ? HTRANS_SEQ
                                     : HTRANS_NONSEQ;
      wd = $urandom;
      do_txn("rand", 1'($urandom_range(0, 1)), tr, a, sz,
             wd, rd);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
